// File: rtl/modn_digit_chain_if.sv
// Command/status bundle for the cascaded modulo-N digit chain.
// master drives commands and reads the chain; slave is the counter itself.
interface modn_digit_chain_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  stop;
    logic                  clear;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic                  tick;
    logic                  up;
    logic [4*DIGITS-1:0]   count;
    logic                  running;
    logic                  done;
    logic                  tc;
    logic                  wrap;

    modport master (
        output start, stop, clear, load, load_value, tick, up,
        input  count, running, done, tc, wrap
    );

    modport slave (
        input  start, stop, clear, load, load_value, tick, up,
        output count, running, done, tc, wrap
    );
endinterface

// File: rtl/modn_digit_chain.sv
// Cascaded per-digit modulo-N up/down counter with load clamping and run/stop/done control.
// Latency: count/running/done/wrap one clk after the edge; tc combinational from count; no backpressure.
module modn_digit_chain #(
    parameter int          DIGITS   = 4,
    parameter logic [31:0] MODS     = 32'h00006A6A,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    modn_digit_chain_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_STOPPED,
        ST_RUNNING,
        ST_DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [DIGITS-1:0][3:0]    count_q, count_d;
    logic                      wrap_q, wrap_d;
    logic                      running_q, done_q;
    logic                      tc;
    logic                      count_en;

    function automatic logic [3:0] digit_max(input int i);
        return MODS[4*i +: 4] - 4'd1;
    endfunction

    always_comb begin
        logic all_max;
        logic all_zero;
        all_max  = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (count_q[i] != digit_max(i)) all_max  = 1'b0;
            if (count_q[i] != 4'd0)         all_zero = 1'b0;
        end
        tc = bus.up ? all_max : all_zero;
    end

    assign count_en = (state_q == ST_RUNNING) && bus.tick && !bus.clear && !bus.load;

    // Ripple enable: a digit steps only when every lower digit is at its rollover value.
    always_comb begin
        logic       step;
        logic [3:0] lv;
        count_d = count_q;
        wrap_d  = 1'b0;
        step    = 1'b1;
        lv      = 4'd0;
        if (bus.clear) begin
            count_d = '0;
        end else if (bus.load) begin
            for (int i = 0; i < DIGITS; i++) begin
                lv         = bus.load_value[4*i +: 4];
                count_d[i] = (lv > digit_max(i)) ? digit_max(i) : lv;
            end
        end else if (count_en) begin
            wrap_d = tc;
            if (!(tc && SATURATE)) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (step) begin
                        if (bus.up)
                            count_d[i] = (count_q[i] == digit_max(i)) ? 4'd0 : count_q[i] + 4'd1;
                        else
                            count_d[i] = (count_q[i] == 4'd0) ? digit_max(i) : count_q[i] - 4'd1;
                    end
                    step = step && (bus.up ? (count_q[i] == digit_max(i)) : (count_q[i] == 4'd0));
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear || bus.load) begin
            state_d = ST_STOPPED;
        end else begin
            case (state_q)
                ST_STOPPED: if (bus.start && !bus.stop) state_d = ST_RUNNING;
                ST_RUNNING: begin
                    // A saturating tick outranks a simultaneous stop.
                    if (count_en && tc && SATURATE) state_d = ST_DONE;
                    else if (bus.stop)              state_d = ST_STOPPED;
                end
                ST_DONE:    state_d = ST_DONE;
                default:    state_d = ST_STOPPED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_STOPPED;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrap_q    <= wrap_d;
            running_q <= (state_d == ST_RUNNING);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign bus.count   = count_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
    assign bus.wrap    = wrap_q;
    assign bus.tc      = tc;
endmodule

// File: tb/tb_modn_digit_chain.sv
// Drives a wrapping and a saturating mm:ss chain with identical stimulus and
// compares both against a mixed-radix integer model of the chain.
module tb_modn_digit_chain;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    modn_digit_chain_if #(.DIGITS(4)) w_if ();
    modn_digit_chain_if #(.DIGITS(4)) s_if ();

    modn_digit_chain #(.DIGITS(4), .MODS(32'h00006A6A), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .bus(w_if));
    modn_digit_chain #(.DIGITS(4), .MODS(32'h00006A6A), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(s_if));

    int total = 0;
    int bad   = 0;

    logic [15:0] mods_v = 16'h6A6A;
    int  mv [2];   // chain value as a plain integer 0..3599
    int  ms [2];   // 0 stopped, 1 running, 2 done
    bit  mw [2];
    bit  cur_up = 1'b1;

    function automatic int span();
        int t = 1;
        for (int i = 0; i < 4; i++) t = t * int'(mods_v[4*i +: 4]);
        return t;
    endfunction

    function automatic int d2v(input logic [15:0] d);
        int v = 0, w = 1;
        for (int i = 0; i < 4; i++) begin
            int m = int'(mods_v[4*i +: 4]);
            int x = int'(d[4*i +: 4]);
            if (x > m - 1) x = m - 1;
            v = v + x * w;
            w = w * m;
        end
        return v;
    endfunction

    function automatic logic [15:0] v2d(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            int m = int'(mods_v[4*i +: 4]);
            r[4*i +: 4] = 4'(v % m);
            v = v / m;
        end
        return r;
    endfunction

    function automatic logic [19:0] exp_v(input int k);
        logic t = cur_up ? (mv[k] == span() - 1) : (mv[k] == 0);
        return {v2d(mv[k]), ms[k] == 1, ms[k] == 2, mw[k], t};
    endfunction

    function automatic logic [19:0] obs_v(input int k);
        if (k == 0) return {w_if.count, w_if.running, w_if.done, w_if.wrap, w_if.tc};
        return {s_if.count, s_if.running, s_if.done, s_if.wrap, s_if.tc};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin mv[k] = 0; ms[k] = 0; mw[k] = 1'b0; end
    endtask

    task automatic model_edge(input int k, input bit sat, input bit st, input bit sp, input bit cl,
                              input bit ld, input logic [15:0] lv, input bit tk, input bit u);
        bit term;
        mw[k] = 1'b0;
        if (cl) begin
            mv[k] = 0; ms[k] = 0;
        end else if (ld) begin
            mv[k] = d2v(lv); ms[k] = 0;
        end else begin
            if (ms[k] == 1 && tk) begin
                term  = u ? (mv[k] == span() - 1) : (mv[k] == 0);
                mw[k] = term;
                if (term && sat)  ms[k] = 2;
                else if (term)    mv[k] = u ? 0 : span() - 1;
                else              mv[k] = u ? mv[k] + 1 : mv[k] - 1;
            end
            if (ms[k] == 0 && st && !sp) ms[k] = 1;
            else if (ms[k] == 1 && sp)   ms[k] = 0;
        end
    endtask

    task automatic set_in(input bit st, input bit sp, input bit cl, input bit ld,
                          input logic [15:0] lv, input bit tk, input bit u);
        w_if.start = st; w_if.stop = sp; w_if.clear = cl; w_if.load = ld;
        w_if.load_value = lv; w_if.tick = tk; w_if.up = u;
        s_if.start = st; s_if.stop = sp; s_if.clear = cl; s_if.load = ld;
        s_if.load_value = lv; s_if.tick = tk; s_if.up = u;
        cur_up = u;
    endtask

    task automatic drive(input bit st, input bit sp, input bit cl, input bit ld,
                         input logic [15:0] lv, input bit tk, input bit u);
        set_in(st, sp, cl, ld, lv, tk, u);
        model_edge(0, 1'b0, st, sp, cl, ld, lv, tk, u);
        model_edge(1, 1'b1, st, sp, cl, ld, lv, tk, u);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 16'h0, 0, 1);
        model_reset();
        #3;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_v(k) !== 20'h0) begin
                bad++; $display("FAIL reset_init dut%0d got=%h want=%h", k, obs_v(k), 20'h0);
            end
        end
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        drive(0, 0, 0, 1, 16'h1234, 0, 1);
        drive(1, 0, 0, 0, 16'h0, 0, 1);
        drive(0, 0, 0, 0, 16'h0, 1, 1);
        set_in(0, 0, 0, 0, 16'h0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_v(k) !== 20'h0) begin
                bad++; $display("FAIL reset_async dut%0d got=%h want=%h", k, obs_v(k), 20'h0);
            end
        end
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_carry();
        logic [15:0] want [3];
        want[0] = 16'h0958; want[1] = 16'h0959; want[2] = 16'h1000;
        drive(0, 0, 0, 1, 16'h0958, 0, 1);
        drive(1, 0, 0, 0, 16'h0, 1, 1);
        for (int n = 0; n < 3; n++) begin
            if (n > 0) drive(0, 0, 0, 0, 16'h0, 1, 1);
            total++;
            if (w_if.count !== want[n] || w_if.wrap !== 1'b0 || w_if.running !== 1'b1) begin
                bad++; $display("FAIL carry%0d got=%h/%b want=%h/0", n, w_if.count, w_if.wrap, want[n]);
            end
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_v(k) !== exp_v(k)) begin
                    bad++; $display("FAIL carry_model%0d dut%0d got=%h want=%h", n, k, obs_v(k), exp_v(k));
                end
            end
        end
    endtask

    task automatic test_wrap();
        drive(0, 0, 0, 1, 16'h5959, 0, 1);
        drive(1, 0, 0, 0, 16'h0, 0, 1);
        drive(0, 0, 0, 0, 16'h0, 1, 1);
        total++;
        if (w_if.count !== 16'h0000 || w_if.wrap !== 1'b1 || w_if.running !== 1'b1) begin
            bad++; $display("FAIL wrap_up got=%h/%b/%b want=0000/1/1", w_if.count, w_if.wrap, w_if.running);
        end
        total++;
        if (s_if.count !== 16'h5959 || s_if.wrap !== 1'b1 || s_if.done !== 1'b1) begin
            bad++; $display("FAIL sat_up got=%h/%b/%b want=5959/1/1", s_if.count, s_if.wrap, s_if.done);
        end
        drive(0, 0, 0, 0, 16'h0, 0, 0);
        total++;
        if (w_if.wrap !== 1'b0) begin
            bad++; $display("FAIL wrap_pulse got=%b want=0", w_if.wrap);
        end
        drive(0, 0, 0, 0, 16'h0, 1, 0);
        total++;
        if (w_if.count !== 16'h5959 || w_if.wrap !== 1'b1) begin
            bad++; $display("FAIL wrap_down got=%h/%b want=5959/1", w_if.count, w_if.wrap);
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_v(k) !== exp_v(k)) begin
                bad++; $display("FAIL wrap_model dut%0d got=%h want=%h", k, obs_v(k), exp_v(k));
            end
        end
    endtask

    task automatic test_saturate();
        drive(0, 0, 0, 1, 16'h0001, 0, 0);
        drive(1, 0, 0, 0, 16'h0, 0, 0);
        drive(0, 0, 0, 0, 16'h0, 1, 0);
        total++;
        if (s_if.count !== 16'h0000 || s_if.tc !== 1'b1 || s_if.wrap !== 1'b0) begin
            bad++; $display("FAIL sat_tc got=%h/%b/%b want=0000/1/0", s_if.count, s_if.tc, s_if.wrap);
        end
        drive(0, 0, 0, 0, 16'h0, 1, 0);
        total++;
        if (s_if.count !== 16'h0000 || s_if.wrap !== 1'b1 || s_if.done !== 1'b1 || s_if.running !== 1'b0) begin
            bad++; $display("FAIL sat_hold got=%h/%b/%b/%b want=0000/1/1/0",
                            s_if.count, s_if.wrap, s_if.done, s_if.running);
        end
        drive(1, 0, 0, 0, 16'h0, 1, 0);
        total++;
        if (s_if.done !== 1'b1 || s_if.running !== 1'b0 || s_if.wrap !== 1'b0) begin
            bad++; $display("FAIL sat_start_ignored got=%b/%b/%b want=1/0/0", s_if.done, s_if.running, s_if.wrap);
        end
        drive(0, 0, 1, 0, 16'h0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_v(k) !== exp_v(k) || obs_v(k) !== 20'h0) begin
                bad++; $display("FAIL sat_clear dut%0d got=%h want=%h", k, obs_v(k), 20'h0);
            end
        end
    endtask

    task automatic test_clamp_cmds();
        drive(0, 0, 0, 1, 16'hFC9B, 0, 1);
        total++;
        if (w_if.count !== 16'h5959 || s_if.count !== 16'h5959) begin
            bad++; $display("FAIL clamp got=%h/%h want=5959", w_if.count, s_if.count);
        end
        drive(1, 1, 0, 0, 16'h0, 0, 1);
        total++;
        if (w_if.running !== 1'b0 || s_if.running !== 1'b0) begin
            bad++; $display("FAIL start_stop got=%b/%b want=0", w_if.running, s_if.running);
        end
        drive(1, 0, 0, 0, 16'h0, 1, 1);
        total++;
        if (w_if.running !== 1'b1 || w_if.count !== 16'h5959 || w_if.wrap !== 1'b0) begin
            bad++; $display("FAIL start_tick got=%b/%h/%b want=1/5959/0", w_if.running, w_if.count, w_if.wrap);
        end
        drive(0, 1, 0, 0, 16'h0, 0, 1);
    endtask

    task automatic test_priority();
        drive(0, 0, 0, 1, 16'h0123, 0, 1);
        drive(1, 0, 0, 0, 16'h0, 0, 1);
        drive(0, 0, 0, 0, 16'h0, 1, 1);
        drive(0, 0, 1, 0, 16'h0, 1, 1);
        total++;
        if (w_if.count !== 16'h0000 || w_if.running !== 1'b0) begin
            bad++; $display("FAIL clear_tick got=%h/%b want=0000/0", w_if.count, w_if.running);
        end
        drive(1, 0, 0, 0, 16'h0, 0, 1);
        drive(0, 0, 0, 1, 16'h0321, 1, 1);
        total++;
        if (w_if.count !== 16'h0321 || w_if.running !== 1'b0) begin
            bad++; $display("FAIL load_tick got=%h/%b want=0321/0", w_if.count, w_if.running);
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_v(k) !== exp_v(k)) begin
                bad++; $display("FAIL prio_model dut%0d got=%h want=%h", k, obs_v(k), exp_v(k));
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] lv;
        int          pick;
        for (int n = 0; n < 600; n++) begin
            pick = int'($urandom_range(0, 3));
            lv = (pick == 0) ? 16'h5959 : (pick == 1) ? 16'h0000 : 16'($urandom);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 29) == 0, lv, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_v(k) !== exp_v(k)) begin
                    bad++; $display("FAIL random%0d dut%0d got=%h want=%h", n, k, obs_v(k), exp_v(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_wrap();
        test_saturate();
        test_clamp_cmds();
        test_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/modn_digit_chain.md
Name: modn_digit_chain

Overview:
- Parametrised cascaded modulo-N digit counter for the watch controller.
- Generalises the single mod-10 digit to a DIGITS-long chain; each digit has its own modulus (e.g. mm:ss = 10,6,10,6).
- Adds up/down counting, tick-qualified enable, load with clamping, and a run-control FSM with optional saturation.
- Sits between the timebase tick generator and the display decoder; also used for timer/alarm digit sets.

Parameters:
- DIGITS, 4, number of 4-bit digits in the chain (1..8).
- MODS, 32'h00006A6A, packed per-digit modulus, 4 bits per digit; digit 0 in bits [3:0]; each value 2..10.
- SATURATE, 0, 1 = stop at terminal count and enter DONE; 0 = wrap and keep running.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled command: STOPPED -> RUNNING.
- stop  in  1  command: RUNNING -> STOPPED.
- clear  in  1  synchronous clear of all digits.
- load  in  1  synchronous load of load_value.
- load_value  in  4*DIGITS  BCD digits to load, digit 0 in LSBs.
- tick  in  1  count strobe, one clk wide.
- up  in  1  direction: 1 = increment, 0 = decrement.
- count  out  4*DIGITS  registered digit values.
- running  out  1  registered; 1 when state = RUNNING.
- done  out  1  registered; 1 when state = DONE.
- tc  out  1  combinational; chain at terminal for current up.
- wrap  out  1  registered one-cycle pulse on terminal crossing or saturation.

Behaviour:
- Reset (reset = 0, asynchronous): count = 0, state = STOPPED, running = 0, done = 0, wrap = 0.
- Priority each edge: clear > load > count > state commands.
- clear: count <= 0; state <= STOPPED; wrap <= 0.
- load: each digit i <= min(load_value digit i, MODS_i - 1), i.e. over-range digits clamp to max; state <= STOPPED; wrap <= 0.
- Counting occurs only when registered state = RUNNING, tick = 1, and no clear/load.
  - A start and a tick in the same cycle from STOPPED: the tick is not counted.
- Up step: digit i increments if all lower digits = MODS-1.
  - A digit at MODS-1 that steps goes to 0.
  - Digit 0 always steps.
- Down step: digit i decrements if all lower digits = 0.
  - A digit at 0 that steps goes to MODS-1.
- tc: up = 1 -> all digits = MODS_i - 1; up = 0 -> all digits = 0.
- Counting tick with tc = 1:
  - SATURATE = 0: chain wraps (up -> all 0; down -> all MODS_i - 1); wrap = 1 for one cycle; state stays RUNNING.
  - SATURATE = 1: count unchanged; wrap = 1 for one cycle; state <= DONE.
- Any other counting tick: wrap <= 0.
- The up input is sampled per tick; direction may change between ticks with no extra latency.
- FSM states: STOPPED, RUNNING, DONE.
  - STOPPED: start & !stop -> RUNNING.
  - RUNNING: stop -> STOPPED (stop wins over simultaneous start); saturation -> DONE.
  - DONE: start and stop ignored; leave only via clear, load, or reset (-> STOPPED).
- Latency: count, running, done, and wrap update one clk after the qualifying edge; tc follows count combinationally.
- Digits never hold a value >= their modulus, by construction.
- Internal arithmetic is 4-bit per digit; no carry out of the top digit except via wrap.

Test Plan:
1. Reset low mid-count at 12:34 -> count = 0, running = 0, done = 0 immediately, without a clock edge.
2. Load 16'h0958, start, 3 ticks up -> 09:58, 09:59, 10:00; the third tick carries across three digits; wrap stays 0.
3. SATURATE = 0, load 59:59, start, 1 tick up -> 00:00, wrap = 1 for one cycle, running stays 1; repeat down from 00:00 -> 59:59, wrap = 1.
4. SATURATE = 1, load 00:01, start, down, 2 ticks -> 00:00 with tc = 1; second tick: count held at 00:00, wrap pulse, done = 1; start ignored; clear -> STOPPED, count 0.
5. Load 16'hFC9B -> count clamps to 16'h5959; start and stop in the same cycle -> stays STOPPED; start with tick in the same cycle -> count unchanged.
6. While running, clear and tick in the same cycle -> count 0, state STOPPED; load and tick in the same cycle -> load_value wins.
